// File: rtl/sm_runctl.sv
// Run controller for a CPU core: holds the core in reset after block reset, then
// runs, halts, single/multi-steps and stops on breakpoint or cycle budget.
module sm_runctl #(
    parameter int RST_HOLD = 4,
    parameter int AUTO_RUN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_count,
    input  logic [31:0] pc,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] cycle_limit,
    output logic        cpu_rst_n,
    output logic        cpu_en,
    output logic        halted,
    output logic [31:0] cycle,
    output logic [1:0]  stop_cause,
    output logic        stop_pulse
);

    typedef enum logic [1:0] {HOLD, HALTED, RUNNING, STEPPING} state_t;

    localparam logic [1:0] OP_CLRCYC = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_STEP   = 2'b11;

    localparam logic [1:0] CAUSE_HOST  = 2'b00;
    localparam logic [1:0] CAUSE_BP    = 2'b01;
    localparam logic [1:0] CAUSE_TOUT  = 2'b10;
    localparam logic [1:0] CAUSE_STEP  = 2'b11;

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

    state_t      state, next_state;
    logic [7:0]  hold_cnt;
    logic [15:0] step_cnt;
    logic        bp_skip;
    logic        accept;
    logic        bp_hit;
    logic        timeout_hit;
    logic        limit_reached;
    logic        stop_event;
    logic [1:0]  next_cause;
    logic        cycle_clear;
    logic        step_load;
    logic        skip_set;
    logic [32:0] cycle_inc;

    assign cmd_ready     = (state != HOLD);
    assign accept        = cmd_valid && cmd_ready;
    assign cpu_rst_n     = (state != HOLD);
    assign halted        = (state == HALTED);
    assign bp_hit        = (state == RUNNING) && bp_en && (pc == bp_addr) && !bp_skip;
    assign cpu_en        = (state == STEPPING) || ((state == RUNNING) && !bp_hit);
    // 33-bit add so the timeout compare stays correct when cycle is saturated
    assign cycle_inc     = {1'b0, cycle} + 33'd1;
    assign timeout_hit   = (cycle_limit != 32'd0) && cpu_en && (cycle_inc >= {1'b0, cycle_limit});
    assign limit_reached = (cycle_limit != 32'd0) && (cycle >= cycle_limit);

    // Stop causes are evaluated in priority order so only one transition fires
    always_comb begin
        next_state  = state;
        stop_event  = 1'b0;
        next_cause  = stop_cause;
        cycle_clear = 1'b0;
        step_load   = 1'b0;
        skip_set    = 1'b0;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST)
                    next_state = (AUTO_RUN != 0) ? RUNNING : HALTED;
            end
            HALTED: begin
                if (accept) begin
                    case (cmd_op)
                        OP_CLRCYC: cycle_clear = 1'b1;
                        OP_RUN, OP_STEP: begin
                            if (limit_reached) begin
                                stop_event = 1'b1;
                                next_cause = CAUSE_TOUT;
                            end else if (cmd_op == OP_RUN) begin
                                next_state = RUNNING;
                                skip_set   = 1'b1;
                            end else begin
                                next_state = STEPPING;
                                step_load  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUNNING: begin
                if (timeout_hit) begin
                    stop_event = 1'b1;
                    next_cause = CAUSE_TOUT;
                end else if (bp_hit) begin
                    stop_event = 1'b1;
                    next_cause = CAUSE_BP;
                end else if (accept && cmd_op == OP_HALT) begin
                    stop_event = 1'b1;
                    next_cause = CAUSE_HOST;
                end
            end
            STEPPING: begin
                if (timeout_hit) begin
                    stop_event = 1'b1;
                    next_cause = CAUSE_TOUT;
                end else if (step_cnt <= 16'd1) begin
                    stop_event = 1'b1;
                    next_cause = CAUSE_STEP;
                end else if (accept && cmd_op == OP_HALT) begin
                    stop_event = 1'b1;
                    next_cause = CAUSE_HOST;
                end
            end
            default: next_state = HOLD;
        endcase
        if (stop_event)
            next_state = HALTED;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HOLD;
            hold_cnt   <= 8'd0;
            cycle      <= 32'd0;
            stop_cause <= CAUSE_HOST;
            stop_pulse <= 1'b0;
            step_cnt   <= 16'd0;
            bp_skip    <= 1'b0;
        end else begin
            state      <= next_state;
            stop_pulse <= stop_event;
            if (stop_event)
                stop_cause <= next_cause;
            hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
            if (cycle_clear)
                cycle <= 32'd0;
            else if (cpu_en && cycle != 32'hFFFF_FFFF)
                cycle <= cycle + 32'd1;
            if (step_load)
                step_cnt <= (cmd_count == 16'd0) ? 16'd1 : cmd_count;
            else if (state == STEPPING && step_cnt != 16'd0)
                step_cnt <= step_cnt - 16'd1;
            // The skip only covers the first RUNNING cycle after a resume
            if (skip_set)
                bp_skip <= 1'b1;
            else if (state == RUNNING)
                bp_skip <= 1'b0;
        end
    end

endmodule
